init_seq_ctrl: RTL
==================

Name: init_seq_ctrl

Overview:
Parametrised power-up sequencer that generalises the board's fixed bring-up order (for example MAC → camera → DDR3 master) to NUM_STAGES stages.
- Releases each stage's reset in turn.
- Waits for that stage's done flag, with a timeout and retries.
- Inserts a settle gap between stages.
- Drives the shared-pin owner select (MDIO/SCCB mux) and an active-low LED progress bar.
- Sits in the top level, clocked by the 27 MHz board clock.

Parameters:
- NUM_STAGES, 4: number of sequenced sub-blocks (2..8).
- CNT_W, 32: width of the delay/timeout counter.
- STAGE_GAP, 27000: idle cycles between one stage's done and the next stage's release (0 allowed).
- TIMEOUT, 27000000: maximum cycles spent waiting for done per attempt (≥2).
- MAX_RETRY, 3: re-attempts per stage after a timeout (0 allowed).
- RST_PULSE, 16: cycles the stage reset is held low during a retry (≥1).
- LED_W, 6: width of the LED progress output.
- SYNC_DONE, 1: 1 = i_stage_done passes through 2-flop synchronisers; 0 = used directly.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- i_start, in, 1: level; begins the sequence when sampled high in IDLE.
- i_restart, in, 1: synchronous soft restart.
- i_stage_done, in, NUM_STAGES: per-stage init-done levels.
- o_stage_rst_n, out, NUM_STAGES: per-stage active-low resets.
- o_bus_owner, out, $clog2(NUM_STAGES): index of the stage owning the shared pins.
- o_busy, out, 1: sequence in progress.
- o_all_done, out, 1: all stages done.
- o_fail, out, 1: a stage exhausted its retries.
- o_fail_stage, out, $clog2(NUM_STAGES): index of the failed stage.
- o_progress, out, LED_W: active-low thermometer, one bit per completed stage.

Behaviour:
- Reset is decided: reset rst_n, asynchronous, active-low; clock clk.
- All outputs are registered.
- Values under rst_n low:
  - o_stage_rst_n = 0, o_bus_owner = 0, o_busy = 0, o_all_done = 0, o_fail = 0, o_fail_stage = 0.
  - o_progress = all ones.
  - state = IDLE, stage = 0, retry = 0, cnt = 0.
- done_s = i_stage_done[stage], after synchronisation when SYNC_DONE = 1 (adds 2 cycles of latency).
- States: IDLE, WAIT_DONE, GAP, RETRY_RST, DONE, FAIL.
- IDLE:
  - On the edge sampling i_start = 1: o_stage_rst_n[0] ← 1, o_bus_owner ← 0, o_busy ← 1, cnt ← 0, enter WAIT_DONE.
- WAIT_DONE:
  - Each cycle cnt++.
  - If done_s: o_progress[stage] ← 0 (only when stage < LED_W). Then go to DONE if stage = NUM_STAGES-1, else to GAP with cnt ← 0.
  - Else, if cnt = TIMEOUT-1: go to RETRY_RST with o_stage_rst_n[stage] ← 0, cnt ← 0, retry++ when retry < MAX_RETRY. Otherwise go to FAIL.
  - done_s has priority over the timeout in the same cycle.
- RETRY_RST:
  - Hold o_stage_rst_n[stage] = 0 for exactly RST_PULSE cycles.
  - Then o_stage_rst_n[stage] ← 1, cnt ← 0, enter WAIT_DONE.
- GAP:
  - Wait STAGE_GAP cycles.
  - Then stage++, retry ← 0, o_stage_rst_n[stage+1] ← 1, o_bus_owner ← stage+1, cnt ← 0, enter WAIT_DONE.
  - With STAGE_GAP = 0, GAP lasts 1 cycle.
- DONE:
  - o_all_done = 1, o_busy = 0.
  - All resets stay high; o_bus_owner holds NUM_STAGES-1.
  - Sticky until rst_n or i_restart.
- FAIL:
  - o_fail = 1, o_fail_stage = stage, o_busy = 0.
  - The failed stage's reset is held low; earlier stages stay released.
  - Sticky until rst_n or i_restart.
- Released stages stay released: a done flag that later drops is ignored, and there is no re-sequencing.
- i_start is ignored outside IDLE; dropping it mid-sequence has no effect.
- i_restart, in any state: on the next edge all outputs return to their reset values and state goes to IDLE.
  - If i_start is also high, the sequence begins on the following edge, not the same one.
  - rst_n overrides i_restart.
- Stages with index ≥ LED_W have no LED bit.
- cnt compares at its full CNT_W width. STAGE_GAP, TIMEOUT and RST_PULSE must each be < 2^CNT_W; an elaboration check enforces this.

Decomposition:
- Package init_seq_pkg: state enum init_seq_state_e (6 encodings, 3 bits) and a function clog2_min1 (returns ≥1 for the owner/index width).
- Sub-module sync_2ff, parametrised width, instantiated on i_stage_done when SYNC_DONE = 1.

Test Plan:
All tests use NUM_STAGES=3, STAGE_GAP=4, TIMEOUT=16, MAX_RETRY=1, RST_PULSE=2, LED_W=6, SYNC_DONE=0.
1. Nominal: i_start at cycle 0, then raise done[0], done[1], done[2] three cycles after each release → resets go 001→011→111, gaps of 4 cycles, o_bus_owner 0→1→2, o_progress 111110→111100→111000, o_all_done = 1, o_busy = 0.
2. Single retry: done[1] first raised 25 cycles after stage-1 release → timeout at 16 cycles, o_stage_rst_n[1] low for exactly 2 cycles, then high again, and the sequence completes.
3. Fail: done[2] never raised → two timeouts, one retry pulse, o_fail = 1, o_fail_stage = 2, o_stage_rst_n = 011, o_all_done = 0.
4. Same-cycle priority: done[0] rises on the cycle cnt = 15 → treated as done, no retry pulse.
5. i_restart in GAP after stage 0, with i_start held high → all outputs reset next edge, o_stage_rst_n[0] re-released one edge later.
6. rst_n asserted asynchronously in WAIT_DONE of stage 1 → outputs reset immediately without a clock edge; LEDs read 111111.
7. Repeat test 1 with SYNC_DONE=1 → each done response is 2 cycles later.

Source files
------------

// File: rtl/init_seq_ctrl_pkg.sv
// Shared types for the power-up sequencer: FSM state encoding and an index-width
// helper that never returns zero, so a 1-bit owner/index field survives 2-stage builds.
// No logic; latency and backpressure not applicable.
package init_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DONE = 3'd1,
        ST_GAP       = 3'd2,
        ST_RETRY_RST = 3'd3,
        ST_DONE      = 3'd4,
        ST_FAIL      = 3'd5
    } init_seq_state_e;

    // Width needed to hold an index 0..n-1, at least 1 bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/init_seq_ctrl_if.sv
// Control/status bundle between the board top and the power-up sequencer.
// slave = sequencer side (consumes start/restart/done, drives resets, owner, status, LEDs);
// master = board side. Level signals only, no handshake or backpressure.
interface init_seq_ctrl_if #(
    parameter int NUM_STAGES = 4,
    parameter int LED_W      = 6
);
    import init_seq_pkg::*;

    localparam int IDX_W = clog2_min1(NUM_STAGES);

    logic                  i_start;
    logic                  i_restart;
    logic [NUM_STAGES-1:0] i_stage_done;
    logic [NUM_STAGES-1:0] o_stage_rst_n;
    logic [IDX_W-1:0]      o_bus_owner;
    logic                  o_busy;
    logic                  o_all_done;
    logic                  o_fail;
    logic [IDX_W-1:0]      o_fail_stage;
    logic [LED_W-1:0]      o_progress;

    modport master (
        output i_start, i_restart, i_stage_done,
        input  o_stage_rst_n, o_bus_owner, o_busy, o_all_done, o_fail, o_fail_stage, o_progress
    );

    modport slave (
        input  i_start, i_restart, i_stage_done,
        output o_stage_rst_n, o_bus_owner, o_busy, o_all_done, o_fail, o_fail_stage, o_progress
    );

endinterface

// File: rtl/init_seq_ctrl_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs (stage done flags).
// Latency: 2 clk cycles. Ports: clk, rst_n, d_i (async levels), q_o (synchronised levels).
// No backpressure; levels are sampled every cycle.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/init_seq_ctrl.sv
// Power-up sequencer: releases NUM_STAGES sub-block resets in order, waits for each done
// flag (timeout + retry with reset pulse), inserts a settle gap, drives the shared-pin
// owner select and an active-low LED progress bar. All outputs registered (1 cycle after
// the deciding edge; done adds 2 cycles when SYNC_DONE=1). No backpressure.
// Ports: clk, rst_n (async, active low); bus (slave modport): i_start, i_restart,
// i_stage_done in; o_stage_rst_n, o_bus_owner, o_busy, o_all_done, o_fail, o_fail_stage,
// o_progress out.
module init_seq_ctrl
    import init_seq_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32,
    parameter int STAGE_GAP  = 27000,
    parameter int TIMEOUT    = 27000000,
    parameter int MAX_RETRY  = 3,
    parameter int RST_PULSE  = 16,
    parameter int LED_W      = 6,
    parameter int SYNC_DONE  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    init_seq_ctrl_if.slave bus
);

    localparam int IDX_W   = clog2_min1(NUM_STAGES);
    localparam int RETRY_W = clog2_min1(MAX_RETRY + 1);

    // Terminal counts; a zero gap still spends the one GAP cycle.
    localparam logic [CNT_W-1:0]      TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST   = CNT_W'((STAGE_GAP == 0) ? 0 : STAGE_GAP - 1);
    localparam logic [CNT_W-1:0]      PULSE_LAST = CNT_W'(RST_PULSE - 1);
    localparam logic [IDX_W-1:0]      LAST_STAGE = IDX_W'(NUM_STAGES - 1);
    localparam logic [RETRY_W-1:0]    RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam logic [NUM_STAGES-1:0] FIRST_OH   = NUM_STAGES'(1);

    // Integer parameters always fit a counter of 31 bits or more; 0 marks that case.
    localparam int CNT_LIM = (CNT_W < 31) ? (1 << CNT_W) : 0;

    generate
        if (NUM_STAGES < 2 || NUM_STAGES > 8) begin : g_bad_stages
            $error("init_seq_ctrl: NUM_STAGES must be 2..8");
        end
        if (TIMEOUT < 2 || RST_PULSE < 1 || STAGE_GAP < 0 || MAX_RETRY < 0 || LED_W < 1) begin : g_bad_timing
            $error("init_seq_ctrl: TIMEOUT>=2, RST_PULSE>=1, STAGE_GAP>=0, MAX_RETRY>=0, LED_W>=1");
        end
        if (CNT_LIM != 0 && (STAGE_GAP >= CNT_LIM || TIMEOUT >= CNT_LIM || RST_PULSE >= CNT_LIM)) begin : g_bad_cnt_w
            $error("init_seq_ctrl: STAGE_GAP, TIMEOUT and RST_PULSE must be < 2**CNT_W");
        end
    endgenerate

    // Done flags, optionally synchronised.
    logic [NUM_STAGES-1:0] done_vec;

    generate
        if (SYNC_DONE != 0) begin : g_sync
            sync_2ff #(.WIDTH(NUM_STAGES)) u_sync_done (
                .clk   (clk),
                .rst_n (rst_n),
                .d_i   (bus.i_stage_done),
                .q_o   (done_vec)
            );
        end else begin : g_nosync
            assign done_vec = bus.i_stage_done;
        end
    endgenerate

    init_seq_state_e       state_q;
    logic [IDX_W-1:0]      stage_q;
    logic [RETRY_W-1:0]    retry_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_STAGES-1:0] stage_rst_n_q;
    logic [IDX_W-1:0]      owner_q;
    logic                  busy_q;
    logic                  all_done_q;
    logic                  fail_q;
    logic [IDX_W-1:0]      fail_stage_q;
    logic [LED_W-1:0]      progress_q;

    // One-hot masks for the current/next stage; stages beyond LED_W get no LED bit.
    logic [IDX_W-1:0]      stage_inc;
    logic [NUM_STAGES-1:0] cur_oh;
    logic [NUM_STAGES-1:0] nxt_oh;
    logic [LED_W-1:0]      led_oh;
    logic                  done_s;

    always_comb begin
        stage_inc = stage_q + 1'b1;
        cur_oh    = '0;
        nxt_oh    = '0;
        led_oh    = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            cur_oh[i] = (i == int'(stage_q));
            nxt_oh[i] = (i == int'(stage_inc));
        end
        for (int i = 0; i < LED_W; i++) begin
            led_oh[i] = (i == int'(stage_q));
        end
        done_s = |(done_vec & cur_oh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            stage_q       <= '0;
            retry_q       <= '0;
            cnt_q         <= '0;
            stage_rst_n_q <= '0;
            owner_q       <= '0;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
            fail_q        <= 1'b0;
            fail_stage_q  <= '0;
            progress_q    <= '1;
        end else if (bus.i_restart) begin
            // Soft restart mirrors reset; i_start is only looked at from the next edge.
            state_q       <= ST_IDLE;
            stage_q       <= '0;
            retry_q       <= '0;
            cnt_q         <= '0;
            stage_rst_n_q <= '0;
            owner_q       <= '0;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
            fail_q        <= 1'b0;
            fail_stage_q  <= '0;
            progress_q    <= '1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        stage_rst_n_q <= FIRST_OH;
                        owner_q       <= '0;
                        busy_q        <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= ST_WAIT_DONE;
                    end
                end

                ST_WAIT_DONE: begin
                    cnt_q <= cnt_q + 1'b1;
                    // done wins over a timeout landing on the same cycle
                    if (done_s) begin
                        progress_q <= progress_q & ~led_oh;
                        cnt_q      <= '0;
                        if (stage_q == LAST_STAGE) begin
                            all_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= ST_DONE;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        stage_rst_n_q <= stage_rst_n_q & ~cur_oh;
                        cnt_q         <= '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 1'b1;
                            state_q <= ST_RETRY_RST;
                        end else begin
                            // failed stage stays in reset, earlier stages stay released
                            fail_q       <= 1'b1;
                            fail_stage_q <= stage_q;
                            busy_q       <= 1'b0;
                            state_q      <= ST_FAIL;
                        end
                    end
                end

                ST_RETRY_RST: begin
                    if (cnt_q == PULSE_LAST) begin
                        stage_rst_n_q <= stage_rst_n_q | cur_oh;
                        cnt_q         <= '0;
                        state_q       <= ST_WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        stage_q       <= stage_inc;
                        retry_q       <= '0;
                        stage_rst_n_q <= stage_rst_n_q | nxt_oh;
                        owner_q       <= stage_inc;
                        cnt_q         <= '0;
                        state_q       <= ST_WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DONE, ST_FAIL: begin
                    // sticky until rst_n or i_restart
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_stage_rst_n = stage_rst_n_q;
    assign bus.o_bus_owner   = owner_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_all_done    = all_done_q;
    assign bus.o_fail        = fail_q;
    assign bus.o_fail_stage  = fail_stage_q;
    assign bus.o_progress    = progress_q;

endmodule
